ahb_dtcm_slave: RTL and testbench

//  AHB-Lite slave fronting the data TCM: the responder for the core's d_h* data master in the LSU.

---
 rtl/ahb_dtcm_slave_pkg.sv | 55 +++++
 rtl/ahb_dtcm_slave_ram.sv | 45 ++++
 rtl/ahb_dtcm_slave.sv | 122 ++++++++++++
 tb/tb_ahb_dtcm_slave.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_dtcm_slave_pkg.sv
// Shared AHB-Lite encodings, FSM states and decode helpers for the DTCM slave.
package ahb_dtcm_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_WAIT = 3'd1,
        ST_DATA = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } dtcm_state_e;

    // Address-phase controls captured on accept
    typedef struct packed {
        logic       write;
        logic       err;
        logic [3:0] strb;
    } dtcm_req_t;

    // NONSEQ and SEQ carry a transfer; IDLE and BUSY do not
    function automatic logic is_active(input logic [1:0] trans);
        return !((trans == HTRANS_IDLE) || (trans == HTRANS_BUSY));
    endfunction

    // Byte-lane strobes for a transfer; illegal sizes produce no lanes
    function automatic logic [3:0] size_strb(input logic [2:0] size, input logic [1:0] a);
        logic [3:0] s;
        case (size)
            HSIZE_BYTE: s = 4'b0001 << a;
            HSIZE_HALF: s = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: s = 4'b1111;
            default:    s = 4'b0000;
        endcase
        return s;
    endfunction

    // Size/alignment part of the error check (range is checked in the top)
    function automatic logic align_err(input logic [2:0] size, input logic [1:0] a);
        return (size > HSIZE_WORD) ||
               ((size == HSIZE_HALF) && a[0]) ||
               ((size == HSIZE_WORD) && (a != 2'b00));
    endfunction

endpackage

// File: rtl/ahb_dtcm_slave_ram.sv
// DEPTH x 32 word array: synchronous read, byte-strobe write, and same-edge
// write-to-read forwarding so a read right behind a write sees the new bytes.
module ahb_dtcm_slave_ram #(
    parameter int DEPTH = 1024,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [IW-1:0] waddr,
    input  logic [3:0]    wstrb,
    input  logic [31:0]   wdata,
    input  logic          re,
    input  logic [IW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rword;
    logic [31:0] merged;

    // Merge write bytes over the current word for the forwarding path
    always_comb begin
        rword  = mem[raddr];
        merged = rword;
        for (int b = 0; b < 4; b++)
            if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end

    // Array write; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we)
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
    end

    // Read register, held between reads; forwards a same-edge write to the same word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rdata <= '0;
        else if (re)
            rdata <= (we && (waddr == raddr)) ? merged : rword;
    end

endmodule

// File: rtl/ahb_dtcm_slave.sv
// AHB-Lite slave fronting the data TCM: decode, error check, wait states and
// two-cycle ERROR response; storage and forwarding live in ahb_dtcm_slave_ram.
module ahb_dtcm_slave
    import ahb_dtcm_slave_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int AW          = 32,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic          hwrite,
    input  logic [2:0]    hsize,
    input  logic [2:0]    hburst,
    input  logic [3:0]    hprot,
    input  logic [31:0]   hwdata,
    input  logic          hready_in,
    output logic          hreadyout,
    output logic [31:0]   hrdata,
    output logic          hresp
);

    localparam int          IW    = $clog2(DEPTH);
    localparam logic [AW:0] LIMIT = (AW+1)'(4 * DEPTH);

    dtcm_state_e   state, nstate;
    logic [3:0]    wcnt;
    dtcm_req_t     req;
    logic [IW-1:0] req_idx;

    logic          accept;
    logic          a_err;
    logic [3:0]    a_strb;
    logic [IW-1:0] a_idx;
    logic          ram_we;
    logic          ram_re;

    // Burst type and protection are not used: every beat decodes on its own
    logic unused_ok;
    assign unused_ok = ^{hburst, hprot};

    assign accept = hsel & is_active(htrans) & hready_in & hreadyout;
    assign a_idx  = haddr[IW+1:2];
    assign a_strb = size_strb(hsize, haddr[1:0]);
    assign a_err  = align_err(hsize, haddr[1:0]) | ({1'b0, haddr} >= LIMIT);

    // Only legal reads touch the read port; writes commit at the end of ST_DATA
    assign ram_re = accept & ~hwrite & ~a_err;
    assign ram_we = (state == ST_DATA) & req.write;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= nstate;
    end

    // Next state: any accept follows the idle-decode rules, otherwise walk the phase
    always_comb begin
        nstate = state;
        if (accept) begin
            if (a_err)                nstate = ST_ERR1;
            else if (WAIT_CYCLES > 0) nstate = ST_WAIT;
            else                      nstate = ST_DATA;
        end else begin
            case (state)
                ST_WAIT: if (wcnt == 4'd0) nstate = ST_DATA;
                ST_DATA: nstate = ST_IDLE;
                ST_ERR1: nstate = ST_ERR2;
                ST_ERR2: nstate = ST_IDLE;
                default: nstate = ST_IDLE;
            endcase
        end
    end

    // Bus response from the current state
    always_comb begin
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        case (state)
            ST_WAIT: hreadyout = 1'b0;
            ST_ERR1: begin hreadyout = 1'b0; hresp = HRESP_ERROR; end
            ST_ERR2: hresp = HRESP_ERROR;
            default: ;
        endcase
    end

    // Wait counter: loaded on accept, ST_WAIT lasts exactly WAIT_CYCLES cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                              wcnt <= '0;
        else if (accept)                         wcnt <= 4'(WAIT_CYCLES - 1);
        else if (state == ST_WAIT && wcnt != '0) wcnt <= wcnt - 4'd1;
    end

    // Capture address-phase controls on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req     <= '0;
            req_idx <= '0;
        end else if (accept) begin
            req.write <= hwrite;
            req.err   <= a_err;
            req.strb  <= a_strb;
            req_idx   <= a_idx;
        end
    end

    ahb_dtcm_slave_ram #(.DEPTH(DEPTH), .IW(IW)) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (ram_we),
        .waddr (req_idx),
        .wstrb (req.strb),
        .wdata (hwdata),
        .re    (ram_re),
        .raddr (a_idx),
        .rdata (hrdata)
    );

endmodule

// File: tb/tb_ahb_dtcm_slave.sv
// Directed bench: u0 has no wait states, u1 has two.
module tb_ahb_dtcm_slave;

    logic        clk, rst_n;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hreadyout0, hreadyout1, hresp0, hresp1;
    logic        hready_in0, hready_in1;
    logic [31:0] hrdata0, hrdata1;

    int checks = 0;
    int failures = 0;

    assign hready_in0 = hreadyout0;
    assign hready_in1 = hreadyout1;

    ahb_dtcm_slave #(.DEPTH(1024), .AW(32), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel0), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hready_in(hready_in0), .hreadyout(hreadyout0),
        .hrdata(hrdata0), .hresp(hresp0));

    ahb_dtcm_slave #(.DEPTH(64), .AW(32), .WAIT_CYCLES(2)) u1 (
        .clk(clk), .rst_n(rst_n), .hsel(hsel1), .haddr(haddr), .htrans(htrans),
        .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hwdata(hwdata), .hready_in(hready_in1), .hreadyout(hreadyout1),
        .hrdata(hrdata1), .hresp(hresp1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        hsel0 = 1'b0; hsel1 = 1'b0; htrans = 2'b00; hwrite = 1'b0;
    endtask

    task automatic addr0(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel0 = 1'b1; hsel1 = 1'b0; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    endtask

    task automatic addr1(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel1 = 1'b1; hsel0 = 1'b0; htrans = 2'b10; hwrite = wr; haddr = a; hsize = sz;
    endtask

    task automatic wr0(input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
        addr0(1'b1, a, sz); step(); idle(); hwdata = d; step();
    endtask

    task automatic rd0(input logic [31:0] a, output logic [31:0] d);
        addr0(1'b0, a, 3'd2); step(); idle(); d = hrdata0; step();
    endtask

    task automatic wait_ready1();
        for (int i = 0; i < 20; i++) begin
            if (hreadyout1) break;
            step();
        end
        checks++;
        if (hreadyout1 !== 1'b1) begin
            failures++;
            $display("FAIL wait_ready1 timeout: hreadyout=%b required 1", hreadyout1);
        end
    endtask

    task automatic wr1(input logic [31:0] a, input logic [31:0] d);
        addr1(1'b1, a, 3'd2); step(); idle(); hwdata = d; wait_ready1(); step();
    endtask

    task automatic rd1(input logic [31:0] a, output logic [31:0] d);
        addr1(1'b0, a, 3'd2); step(); idle(); wait_ready1(); d = hrdata1; step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; #12;
        checks++;
        if ({hreadyout0, hresp0, hrdata0} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_u0: rdy=%b resp=%b rdata=%h required 1 0 0", hreadyout0, hresp0, hrdata0);
        end
        checks++;
        if ({hreadyout1, hresp1, hrdata1} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_u1: rdy=%b resp=%b rdata=%h required 1 0 0", hreadyout1, hresp1, hrdata1);
        end
        step(); rst_n = 1'b1; step();
    endtask

    task automatic test_write_read();
        logic [31:0] d;
        addr0(1'b1, 32'h10, 3'd2); step();
        checks++;
        if (hreadyout0 !== 1'b1) begin
            failures++; $display("FAIL wr_rd_ready: hreadyout=%b required 1", hreadyout0);
        end
        addr0(1'b0, 32'h10, 3'd2); hwdata = 32'hDEADBEEF; step();
        checks++;
        if ({hreadyout0, hresp0, hrdata0} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
            failures++;
            $display("FAIL wr_rd_b2b: rdy=%b resp=%b rdata=%h required 1 0 deadbeef", hreadyout0, hresp0, hrdata0);
        end
        idle(); step();
        rd0(32'h10, d);
        checks++;
        if (d !== 32'hDEADBEEF) begin
            failures++; $display("FAIL wr_rd_again: rdata=%h required deadbeef", d);
        end
    endtask

    task automatic test_forward_strobes();
        logic [31:0] d;
        wr0(32'h4, 32'h11223344, 3'd2);
        addr0(1'b1, 32'h5, 3'd0); step();
        addr0(1'b0, 32'h4, 3'd2); hwdata = 32'h0000AB00; step();
        checks++;
        if (hrdata0 !== 32'h1122AB44) begin
            failures++; $display("FAIL fwd_byte: rdata=%h required 1122ab44", hrdata0);
        end
        idle(); step();
        wr0(32'h6, 32'hBEEF0000, 3'd1);
        rd0(32'h4, d);
        checks++;
        if (d !== 32'hBEEFAB44) begin
            failures++; $display("FAIL half_write: rdata=%h required beefab44", d);
        end
        // back-to-back byte writes to the same lane: the later one wins
        addr0(1'b1, 32'h4, 3'd0); step();
        addr0(1'b1, 32'h4, 3'd0); hwdata = 32'h00000011; step();
        idle(); hwdata = 32'h00000022; step();
        rd0(32'h4, d);
        checks++;
        if (d !== 32'hBEEFAB22) begin
            failures++; $display("FAIL b2b_writes: rdata=%h required beefab22", d);
        end
    endtask

    task automatic test_misaligned();
        wr0(32'h0, 32'hCAFEF00D, 3'd2);
        addr0(1'b0, 32'h2, 3'd2); step();
        checks++;
        if ({hreadyout0, hresp0} !== 2'b01) begin
            failures++; $display("FAIL err1_word: rdy=%b resp=%b required 0 1", hreadyout0, hresp0);
        end
        idle(); step();
        checks++;
        if ({hreadyout0, hresp0} !== 2'b11) begin
            failures++; $display("FAIL err2_word: rdy=%b resp=%b required 1 1", hreadyout0, hresp0);
        end
        addr0(1'b0, 32'h0, 3'd2); step();
        checks++;
        if ({hreadyout0, hresp0, hrdata0} !== {1'b1, 1'b0, 32'hCAFEF00D}) begin
            failures++;
            $display("FAIL after_err_read: rdy=%b resp=%b rdata=%h required 1 0 cafef00d", hreadyout0, hresp0, hrdata0);
        end
        idle(); step();
        addr0(1'b0, 32'h1, 3'd1); step();
        checks++;
        if ({hreadyout0, hresp0} !== 2'b01) begin
            failures++; $display("FAIL err_half_odd: rdy=%b resp=%b required 0 1", hreadyout0, hresp0);
        end
        idle(); step(); step();
        addr0(1'b0, 32'h0, 3'd3); step();
        checks++;
        if ({hreadyout0, hresp0} !== 2'b01) begin
            failures++; $display("FAIL err_size3: rdy=%b resp=%b required 0 1", hreadyout0, hresp0);
        end
        idle(); step(); step();
    endtask

    task automatic test_out_of_range();
        logic [31:0] d;
        wr0(32'h0, 32'h01020304, 3'd2);
        wr0(32'hFFC, 32'hA5A5A5A5, 3'd2);
        addr0(1'b1, 32'h1000, 3'd2); step();
        checks++;
        if ({hreadyout0, hresp0} !== 2'b01) begin
            failures++; $display("FAIL oor_err1: rdy=%b resp=%b required 0 1", hreadyout0, hresp0);
        end
        idle(); hwdata = 32'hFFFFFFFF; step();
        checks++;
        if ({hreadyout0, hresp0} !== 2'b11) begin
            failures++; $display("FAIL oor_err2: rdy=%b resp=%b required 1 1", hreadyout0, hresp0);
        end
        step();
        rd0(32'h0, d);
        checks++;
        if (d !== 32'h01020304) begin
            failures++; $display("FAIL oor_word0: rdata=%h required 01020304", d);
        end
        rd0(32'hFFC, d);
        checks++;
        if (d !== 32'hA5A5A5A5) begin
            failures++; $display("FAIL oor_wordlast: rdata=%h required a5a5a5a5", d);
        end
        addr0(1'b0, 32'hFFF, 3'd0); step();
        checks++;
        if ({hresp0, hrdata0} !== {1'b0, 32'hA5A5A5A5}) begin
            failures++; $display("FAIL last_byte: resp=%b rdata=%h required 0 a5a5a5a5", hresp0, hrdata0);
        end
        idle(); step();
    endtask

    task automatic test_wait_states();
        wr1(32'h8, 32'h0BADCAFE);
        addr1(1'b0, 32'h8, 3'd2); step();
        checks++;
        if (hreadyout1 !== 1'b0) begin
            failures++; $display("FAIL wait_c1: hreadyout=%b required 0", hreadyout1);
        end
        hsel1 = 1'b1; htrans = 2'b00; haddr = 32'h20; step();
        checks++;
        if (hreadyout1 !== 1'b0) begin
            failures++; $display("FAIL wait_c2: hreadyout=%b required 0", hreadyout1);
        end
        step();
        checks++;
        if ({hreadyout1, hresp1, hrdata1} !== {1'b1, 1'b0, 32'h0BADCAFE}) begin
            failures++;
            $display("FAIL wait_data: rdy=%b resp=%b rdata=%h required 1 0 0badcafe", hreadyout1, hresp1, hrdata1);
        end
        idle(); step();
        checks++;
        if (hreadyout1 !== 1'b1) begin
            failures++; $display("FAIL wait_idle_after: hreadyout=%b required 1", hreadyout1);
        end
    endtask

    task automatic test_reset_mid_write();
        logic [31:0] d;
        wr1(32'h20, 32'h55AA55AA);
        addr1(1'b1, 32'h20, 3'd2); step();
        idle(); hwdata = 32'h12345678;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({hreadyout1, hresp1, hrdata1} !== {1'b1, 1'b0, 32'h0}) begin
            failures++;
            $display("FAIL reset_in_wait: rdy=%b resp=%b rdata=%h required 1 0 0", hreadyout1, hresp1, hrdata1);
        end
        step(); step(); rst_n = 1'b1; step();
        rd1(32'h20, d);
        checks++;
        if (d !== 32'h55AA55AA) begin
            failures++; $display("FAIL reset_dropped_write: rdata=%h required 55aa55aa", d);
        end
    endtask

    initial begin
        idle();
        haddr = '0; hsize = 3'd2; hburst = '0; hprot = '0; hwdata = '0;
        test_reset();
        test_write_read();
        test_forward_strobes();
        test_misaligned();
        test_out_of_range();
        test_wait_states();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
